// File: rtl/accel_cmd_sequencer.sv
// Command FIFO plus start/busy/done initiator for one vector engine.
// Define ACCEL_SEQ_TIMEOUT_EN to enable the RUN-state watchdog (TIMEOUT_CYCLES).
package accel_cmd_sequencer_pkg;
  typedef enum logic [1:0] {
    COMP_ADD = 2'd0,
    COMP_SUB = 2'd1,
    COMP_MUL = 2'd2,
    COMP_MAC = 2'd3
  } computation_type_t;
endpackage

module accel_cmd_sequencer
  import accel_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  computation_type_t cmd_op_i,
  input  logic [4:0]        cmd_count_i,
  output logic              eng_start_o,
  output computation_type_t eng_op_o,
  output logic [4:0]        eng_max_count_o,
  input  logic              eng_busy_i,
  input  logic              eng_done_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [1:0]        rsp_status_o,
  output logic [5:0]        rsp_cycles_o,
  output logic              idle_o
);

  localparam int PtrW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : gBadParams
    $error("accel_cmd_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES nonzero");
  end

`ifdef ACCEL_SEQ_TIMEOUT_EN
  localparam logic [5:0] TimeoutSat = (TIMEOUT_CYCLES > 63) ? 6'd63 : 6'(TIMEOUT_CYCLES);
`endif

  typedef struct packed {
    computation_type_t op;
    logic [4:0]        count;
  } cmdEntry_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2,
    StResp  = 2'd3
  } state_t;

  cmdEntry_t         fifoMem_q [DEPTH];
  logic [PtrW:0]     wrPtr_q, rdPtr_q;
  state_t            state_q, state_d;
  computation_type_t op_q, op_d;
  logic [4:0]        maxCount_q, maxCount_d;
  logic [5:0]        cycles_q, cycles_d;
  logic [1:0]        status_q, status_d;
  logic              full, empty, push, pop, engStart;
  logic [5:0]        cyclesInc;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[PtrW] != rdPtr_q[PtrW]) &&
                 (wrPtr_q[PtrW-1:0] == rdPtr_q[PtrW-1:0]);
  assign push  = cmd_valid_i && !full;

  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q[PtrW-1:0]] <= {cmd_op_i, cmd_count_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + (PtrW + 1)'(1);
      if (pop)  rdPtr_q <= rdPtr_q + (PtrW + 1)'(1);
    end
  end

  assign cyclesInc = (cycles_q == 6'd63) ? 6'd63 : cycles_q + 6'd1;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    maxCount_d = maxCount_q;
    cycles_d   = cycles_q;
    status_d   = status_q;
    pop        = 1'b0;
    engStart   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop        = 1'b1;
          op_d       = fifoMem_q[rdPtr_q[PtrW-1:0]].op;
          maxCount_d = fifoMem_q[rdPtr_q[PtrW-1:0]].count;
          state_d    = StStart;
        end
      end
      StStart: begin
        // A done pulse here belongs to nobody, but still means the engine is not ready.
        if (!(eng_busy_i || eng_done_i)) begin
          engStart = 1'b1;
          cycles_d = 6'd0;
          status_d = 2'b00;
          state_d  = StRun;
        end
      end
      StRun: begin
        cycles_d = cyclesInc;
        if (eng_done_i) begin
          status_d = 2'b00;
          state_d  = StResp;
        end
`ifdef ACCEL_SEQ_TIMEOUT_EN
        else if (cyclesInc >= TimeoutSat) begin
          status_d = 2'b01;
          cycles_d = TimeoutSat;
          state_d  = StResp;
        end
`endif
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= computation_type_t'(2'd0);
      maxCount_q <= 5'd0;
      cycles_q   <= 6'd0;
      status_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      maxCount_q <= maxCount_d;
      cycles_q   <= cycles_d;
      status_q   <= status_d;
    end
  end

  assign cmd_ready_o     = !full;
  assign eng_start_o     = engStart;
  assign eng_op_o        = op_q;
  assign eng_max_count_o = maxCount_q;
  assign rsp_valid_o     = (state_q == StResp);
  assign rsp_status_o    = status_q;
  assign rsp_cycles_o    = cycles_q;
  assign idle_o          = empty && (state_q == StIdle);

endmodule

// File: tb/tb_accel_cmd_sequencer.sv
// Self-checking bench for accel_cmd_sequencer with a status-controller style engine model.
// Timeout expectations follow ACCEL_SEQ_TIMEOUT_EN when it is defined for the build.
module tb_accel_cmd_sequencer;
  import accel_cmd_sequencer_pkg::*;

  localparam int Depth   = 4;
  localparam int Timeout = 48;

  typedef struct {
    computation_type_t op;
    int                count;
  } modelCmd_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmdValid = 1'b0;
  computation_type_t cmdOp = COMP_ADD;
  logic [4:0]        cmdCount = 5'd0;
  logic              rspReady = 1'b1;
  logic              engBusy, engDone;
  logic              cmdReady, engStart, rspValid, idle;
  computation_type_t engOp;
  logic [4:0]        engMaxCount;
  logic [1:0]        rspStatus;
  logic [5:0]        rspCycles;

  logic engBusyModel = 1'b0, engDoneModel = 1'b0;
  logic forceBusy = 1'b0, forceDone = 1'b0, neverDone = 1'b0;
  assign engBusy = engBusyModel | forceBusy;
  assign engDone = engDoneModel | forceDone;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  accel_cmd_sequencer #(.DEPTH(Depth), .TIMEOUT_CYCLES(Timeout)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid_i    (cmdValid),
    .cmd_ready_o    (cmdReady),
    .cmd_op_i       (cmdOp),
    .cmd_count_i    (cmdCount),
    .eng_start_o    (engStart),
    .eng_op_o       (engOp),
    .eng_max_count_o(engMaxCount),
    .eng_busy_i     (engBusy),
    .eng_done_i     (engDone),
    .rsp_valid_o    (rspValid),
    .rsp_ready_i    (rspReady),
    .rsp_status_o   (rspStatus),
    .rsp_cycles_o   (rspCycles),
    .idle_o         (idle)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no event, expected one within budget (cycle %0d)", name, cyc);
  endtask

  // Transaction model: a queue of pending commands plus timestamps of the active one.
  modelCmd_t         mq[$];
  modelCmd_t         cur, inCmd;
  bit                haveCur = 0, pushOk;
  int                startCyc = -1, endCyc = -1, runLen;
  logic [1:0]        mStatus = 2'b00;
  int                mCycles = 0, mCnt = 0;
  computation_type_t mOp = COMP_ADD;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      haveCur  = 0;
      startCyc = -1;
      endCyc   = -1;
      mStatus  = 2'b00;
      mCycles  = 0;
      mOp      = COMP_ADD;
      mCnt     = 0;
    end else begin
      pushOk      = cmdValid && (mq.size() < Depth);
      inCmd.op    = cmdOp;
      inCmd.count = int'(cmdCount);
      if (!haveCur) begin
        if (mq.size() > 0) begin
          cur      = mq.pop_front();
          haveCur  = 1;
          startCyc = -1;
          endCyc   = -1;
          mOp      = cur.op;
          mCnt     = cur.count;
        end
      end else if (startCyc < 0) begin
        if (!(engBusy || engDone)) startCyc = cyc;
      end else if (endCyc < 0) begin
        runLen = cyc - startCyc;
        if (engDone) begin
          endCyc  = cyc;
          mStatus = 2'b00;
          mCycles = (runLen > 63) ? 63 : runLen;
        end
`ifdef ACCEL_SEQ_TIMEOUT_EN
        else if (runLen >= Timeout) begin
          endCyc  = cyc;
          mStatus = 2'b01;
          mCycles = (Timeout > 63) ? 63 : Timeout;
        end
`endif
      end else if (rspReady) begin
        haveCur = 0;
      end
      if (pushOk) mq.push_back(inCmd);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cmd_ready", cmdReady, mq.size() < Depth);
      checkOutput("idle", idle, !haveCur && mq.size() == 0);
      checkOutput("eng_start", engStart, haveCur && startCyc < 0 && !(engBusy || engDone));
      checkOutput("eng_op", 32'(engOp), 32'(mOp));
      checkOutput("eng_max_count", engMaxCount, mCnt);
      checkOutput("rsp_valid", rspValid, haveCur && endCyc >= 0);
      if (haveCur && endCyc >= 0) begin
        checkOutput("rsp_status", rspStatus, mStatus);
        checkOutput("rsp_cycles", rspCycles, mCycles);
      end
    end
  end

  int startCount = 0, lastStartCyc = -1, rspValidSeen = 0;
  int rspLog[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (engStart) begin
        startCount++;
        lastStartCyc = cyc;
      end
      if (rspValid) rspValidSeen++;
      if (rspValid && rspReady) rspLog.push_back(int'(rspCycles));
    end
  end

  // Engine: busy from start+1, done pulse at start+N+2 unless neverDone holds it forever.
  bit engActive = 0;
  int engDoneAt = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n && engStart) begin
      engActive = 1;
      engDoneAt = cyc + int'(engMaxCount) + 2;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      engActive    = 0;
      engBusyModel = 1'b0;
      engDoneModel = 1'b0;
    end else begin
      engBusyModel = engActive && (neverDone || cyc < engDoneAt);
      engDoneModel = engActive && !neverDone && cyc == engDoneAt;
      if (engActive && !neverDone && cyc >= engDoneAt) engActive = 0;
    end
  end

  task automatic toDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input computation_type_t op, input int count, output int acceptCyc);
    cmdValid  = 1'b1;
    cmdOp     = op;
    cmdCount  = 5'(count);
    acceptCyc = -1;
    for (int i = 0; i < 200 && acceptCyc < 0; i++) begin
      @(negedge clk);
      if (cmdReady) acceptCyc = cyc;
      @(posedge clk);
      #1;
    end
    cmdValid = 1'b0;
    if (acceptCyc < 0) failTimeout("accept");
  endtask

  task automatic waitRspValid(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = rspValid;
    end
    if (!got) failTimeout("rsp_valid_wait");
  endtask

  task automatic waitIdle(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = idle;
    end
    if (!got) failTimeout("idle_wait");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, s0, seen0, held, logBase, fall;
    bit got;
    int expSeq[6];

    @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", cmdReady, 1);
    checkOutput("reset_eng_start", engStart, 0);
    checkOutput("reset_eng_op", 32'(engOp), 0);
    checkOutput("reset_eng_max_count", engMaxCount, 0);
    checkOutput("reset_rsp_valid", rspValid, 0);
    checkOutput("reset_rsp_status", rspStatus, 0);
    checkOutput("reset_rsp_cycles", rspCycles, 0);
    checkOutput("reset_idle", idle, 1);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] single command ADD count 5");
    rspReady = 1'b1;
    s0 = startCount;
    applyStimulus(COMP_ADD, 5, acc);
    waitRspValid(40);
    checkOutput("t1_rsp_cycles", rspCycles, 7);
    checkOutput("t1_rsp_status", rspStatus, 0);
    checkOutput("t1_eng_max_count", engMaxCount, 5);
    checkOutput("t1_start_latency", lastStartCyc - acc, 2);
    waitIdle(10);
    toDrive();
    checkOutput("t1_start_count", startCount - s0, 1);

    $display("[TB] stalled response with FIFO filling behind it");
    rspReady = 1'b0;
    applyStimulus(COMP_SUB, 7, acc);
    waitRspValid(40);
    held = startCount;
    checkOutput("t3_rsp_cycles", rspCycles, 9);
    toDrive();
    for (int i = 0; i < 4; i++) applyStimulus(COMP_MUL, i, acc);
    @(negedge clk);
    checkOutput("t2_ready_low_when_full", cmdReady, 0);
    toDrive();
    cmdValid = 1'b1;
    cmdOp    = COMP_MAC;
    cmdCount = 5'd4;
    tick(6);
    @(negedge clk);
    checkOutput("t3_no_new_start", startCount - held, 0);
    checkOutput("t3_rsp_valid_held", rspValid, 1);
    checkOutput("t3_rsp_cycles_held", rspCycles, 9);
    toDrive();
    logBase  = rspLog.size();
    rspReady = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = cmdReady;
      @(posedge clk);
      #1;
    end
    cmdValid = 1'b0;
    if (!got) failTimeout("t2_fifth_accept");
    waitIdle(200);
    expSeq = '{9, 2, 3, 4, 5, 6};
    if (rspLog.size() < logBase + 6) failTimeout("t2_response_count");
    else for (int i = 0; i < 6; i++) checkOutput($sformatf("t2_rsp_order_%0d", i), rspLog[logBase + i], expSeq[i]);
    toDrive();

    $display("[TB] stray done while idle, then busy held through START");
    forceDone = 1'b1;
    s0 = startCount;
    tick(1);
    forceDone = 1'b0;
    @(negedge clk);
    checkOutput("t4_idle_after_stray_done", idle, 1);
    toDrive();
    forceBusy = 1'b1;
    applyStimulus(COMP_ADD, 2, acc);
    tick(7);
    checkOutput("t4_start_withheld", startCount - s0, 0);
    forceBusy = 1'b0;
    fall = cyc;
    waitRspValid(30);
    checkOutput("t4_start_cycle", lastStartCyc, fall);
    checkOutput("t4_rsp_cycles", rspCycles, 4);
    waitIdle(10);
    toDrive();

    $display("[TB] reset during RUN with commands queued");
    neverDone = 1'b1;
    applyStimulus(COMP_ADD, 1, acc);
    applyStimulus(COMP_SUB, 2, acc);
    applyStimulus(COMP_MUL, 3, acc);
    tick(5);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_cmd_ready", cmdReady, 1);
    checkOutput("t5_eng_start", engStart, 0);
    checkOutput("t5_eng_op", 32'(engOp), 0);
    checkOutput("t5_eng_max_count", engMaxCount, 0);
    checkOutput("t5_rsp_valid", rspValid, 0);
    checkOutput("t5_idle", idle, 1);
    neverDone = 1'b0;
    tick(2);
    rst_n = 1'b1;
    s0    = startCount;
    seen0 = rspValidSeen;
    tick(20);
    @(negedge clk);
    checkOutput("t5_no_start_after_reset", startCount - s0, 0);
    checkOutput("t5_no_rsp_after_reset", rspValidSeen - seen0, 0);
    checkOutput("t5_idle_after_reset", idle, 1);
    toDrive();

    $display("[TB] engine never signals done");
    neverDone = 1'b1;
    rspReady  = 1'b0;
    s0    = startCount;
    seen0 = rspValidSeen;
    applyStimulus(COMP_MAC, 3, acc);
`ifdef ACCEL_SEQ_TIMEOUT_EN
    waitRspValid(120);
    checkOutput("t6_status_timeout", rspStatus, 1);
    checkOutput("t6_cycles_timeout", rspCycles, 48);
    checkOutput("t6_timeout_latency", cyc - lastStartCyc, 49);
`else
    tick(200);
    @(negedge clk);
    checkOutput("t6_no_response", rspValidSeen - seen0, 0);
    checkOutput("t6_single_start", startCount - s0, 1);
`endif
    toDrive();
    rst_n     = 1'b0;
    neverDone = 1'b0;
    rspReady  = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
